// File: rtl/rd_pkg.sv
// Shared types, default sizes and helpers for the serial reward decider.
// The sum width leaves headroom for L lanes of full-width weighted penalties.
package rd_pkg;

    localparam int RD_N_INT  = 2;
    localparam int RD_N_LANE = 4;
    localparam int RD_LVL_W  = 3;
    localparam int RD_RW     = 32;
    localparam int L         = RD_N_INT * RD_N_LANE;
    localparam int SUM_W     = RD_RW + RD_LVL_W + $clog2(L) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } rd_state_t;

    function automatic logic signed [RD_RW-1:0] sat_rw(
        input logic signed [SUM_W-1:0] v
    );
        logic [SUM_W-RD_RW:0] top;
        top = v[SUM_W-1:RD_RW-1];
        if ((&top) || !(|top)) begin
            return v[RD_RW-1:0];
        end else if (v[SUM_W-1]) begin
            return {1'b1, {(RD_RW-1){1'b0}}};
        end else begin
            return {1'b0, {(RD_RW-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/rd_sat_add.sv
// Signed two's-complement adder that clamps to the W-bit range.
module rd_sat_add #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    logic signed [W:0] s;

    always_comb begin
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) begin
            y = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = s[W-1:0];
        end
    end

endmodule

// File: rtl/reward_decider_seq.sv
// Serial lane scorer: one lane per cycle, saturated step reward and
// a saturating per-episode accumulator behind valid/ready handshakes.
module reward_decider_seq
    import rd_pkg::*;
#(
    parameter int N_INT  = RD_N_INT,
    parameter int N_LANE = RD_N_LANE,
    parameter int LVL_W  = RD_LVL_W,
    parameter int RW     = RD_RW
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [N_INT*N_LANE*LVL_W-1:0]         s_state,
    input  logic signed [RW-1:0]                  r_pos,
    input  logic signed [RW-1:0]                  r_neg,
    input  logic                                  mode,
    input  logic                                  ep_clr,
    output logic                                  r_valid,
    input  logic                                  r_ready,
    output logic signed [RW-1:0]                  r,
    output logic [$clog2(N_INT*N_LANE+1)-1:0]     zero_cnt,
    output logic signed [RW-1:0]                  acc
);

    localparam int NL = N_INT * N_LANE;
    localparam int SW = RW + LVL_W + $clog2(NL) + 1;
    localparam int IW = $clog2(NL);
    localparam int ZW = $clog2(NL + 1);

    rd_state_t state_q, state_d;

    logic [NL*LVL_W-1:0]    st_q;
    logic signed [RW-1:0]   rpos_q, rneg_q;
    logic                   mode_q;
    logic [IW-1:0]          idx;
    logic signed [SW-1:0]   sum, sum_nx, contrib;
    logic [ZW-1:0]          zc, zc_nx;
    logic [LVL_W-1:0]       lvl;
    logic signed [RW+LVL_W:0] prod;
    logic                   accept, last, hs;
    logic signed [RW-1:0]   acc_base, acc_nx;

    assign s_ready = (state_q == IDLE);
    assign r_valid = (state_q == DONE);
    assign accept  = s_valid && s_ready;
    assign hs      = r_valid && r_ready;
    assign last    = (idx == IW'(NL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)  state_d = SCAN;
            SCAN: if (last)    state_d = DONE;
            DONE: if (r_ready) state_d = IDLE;
            default:           state_d = IDLE;
        endcase
    end

    // Weighted penalty uses the full product; level is unsigned
    always_comb begin
        lvl  = st_q[idx*LVL_W +: LVL_W];
        prod = rneg_q * $signed({1'b0, lvl});
        if (lvl == '0) begin
            contrib = {{(SW-RW){rpos_q[RW-1]}}, rpos_q};
        end else if (!mode_q) begin
            contrib = -{{(SW-RW){rneg_q[RW-1]}}, rneg_q};
        end else begin
            contrib = -{{(SW-RW-LVL_W-1){prod[RW+LVL_W]}}, prod};
        end
        sum_nx = sum + contrib;
        zc_nx  = zc + ZW'(lvl == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= '0;
            rpos_q   <= '0;
            rneg_q   <= '0;
            mode_q   <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            zc       <= '0;
            r        <= '0;
            zero_cnt <= '0;
        end else if (accept) begin
            st_q   <= s_state;
            rpos_q <= r_pos;
            rneg_q <= r_neg;
            mode_q <= mode;
            idx    <= '0;
            sum    <= '0;
            zc     <= '0;
        end else if (state_q == SCAN) begin
            sum <= sum_nx;
            zc  <= zc_nx;
            idx <= idx + 1'b1;
            if (last) begin
                r        <= sat_rw(sum_nx);
                zero_cnt <= zc_nx;
            end
        end
    end

    // Clearing on a handshake restarts the episode with this step's reward
    assign acc_base = ep_clr ? '0 : acc;

    rd_sat_add #(.W(RW)) u_acc_add (
        .a (acc_base),
        .b (r),
        .y (acc_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         acc <= '0;
        else if (hs)     acc <= acc_nx;
        else if (ep_clr) acc <= '0;
    end

endmodule
